// File: rtl/fpu_issue_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : fpu_issue_seq
//  Description : Pipelined issue/retire sequencer for the FPU datapath.
//                Accepts one op per cycle on a valid/ready handshake. It sends
//                registered operands and a one-hot start pulse to the unit
//                selected by the op code. A shift-register scoreboard captures
//                each unit result on its exact completion cycle and returns it
//                with the caller's tag.
//
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid / in_ready  - op request handshake
//                in_ctl, in_tag       - op code and caller tag
//                in_x1, in_x2         - operands
//                flush                - discard every in-flight op
//                unit_go              - one-hot one-cycle unit start pulse
//                unit_x1, unit_x2     - registered operands to the units
//                unit_y               - unit result buses, slice k = ctl k
//                out_valid            - one-cycle result strobe
//                out_tag, out_y       - tag and result of the retired op
//                out_err              - illegal-op flag
//                inflight             - number of outstanding ops
//
//  Config      : FPU_ISSUE_ILLEGAL_TRAP_EN
//                  defined   - an illegal op code (latency 0) is accepted and
//                              returned two cycles later with out_err=1 and
//                              out_y=0
//                  undefined - an illegal op code is accepted and dropped;
//                              out_err is always 0
//
//  Revision    : 1.0 - initial release
// ============================================================================

module fpu_issue_seq #(
    parameter int                      WIDTH     = 32,
    parameter int                      CTL_W     = 4,
    parameter int                      TAG_W     = 4,
    parameter int                      MAX_LAT   = 15,
    parameter logic [4*(2**CTL_W)-1:0] LAT_TABLE = 64'h0111_1000_1943_2200
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CTL_W-1:0]                in_ctl,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic [WIDTH-1:0]                in_x1,
    input  logic [WIDTH-1:0]                in_x2,
    input  logic                            flush,
    output logic [(2**CTL_W)-1:0]           unit_go,
    output logic [WIDTH-1:0]                unit_x1,
    output logic [WIDTH-1:0]                unit_x2,
    input  logic [(2**CTL_W)*WIDTH-1:0]     unit_y,
    output logic                            out_valid,
    output logic [TAG_W-1:0]                out_tag,
    output logic [WIDTH-1:0]                out_y,
    output logic                            out_err,
    output logic [$clog2(MAX_LAT+2)-1:0]    inflight
);

    localparam int NOP    = 2**CTL_W;
    localparam int NSLOT  = MAX_LAT + 2;
    localparam int SLOT_W = $clog2(NSLOT);
    localparam int INF_W  = $clog2(MAX_LAT + 2);

    // Compare ops return a single flag in bit 0 of their unit slice.
    localparam logic [CTL_W-1:0] CTL_FEQ = CTL_W'(11);
    localparam logic [CTL_W-1:0] CTL_FLE = CTL_W'(12);

    // ------------------------------------------------------------------
    // Unpack the latency table and the unit result buses
    // ------------------------------------------------------------------
    logic [3:0]       lat_tab [NOP];
    logic [WIDTH-1:0] y_tab   [NOP];

    for (genvar k = 0; k < NOP; k++) begin : g_unpack
        assign lat_tab[k] = LAT_TABLE[4*k +: 4];
        assign y_tab[k]   = unit_y[k*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // due_q[i] set means an op's result is on its unit bus i cycles from
    // now; slot 0 is sampled at the end of the current cycle.
    logic [NSLOT-1:0]  due_q,  due_d;
    logic [TAG_W-1:0]  tag_q  [NSLOT];
    logic [TAG_W-1:0]  tag_d  [NSLOT];
    logic [CTL_W-1:0]  ctl_q  [NSLOT];
    logic [CTL_W-1:0]  ctl_d  [NSLOT];

    logic [NOP-1:0]    go_q,   go_d;
    logic [WIDTH-1:0]  x1_q,   x2_q;
    logic              ov_q,   ov_d;
    logic [TAG_W-1:0]  otag_q, otag_d;
    logic [WIDTH-1:0]  oy_q,   oy_d;
    logic              oerr_q, oerr_d;
    logic [INF_W-1:0]  inf_q,  inf_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [3:0]        in_lat;
    logic              in_legal;
    logic [SLOT_W-1:0] in_slot;
    logic              accept;
    logic              enq;
    logic              ret;
    logic [CTL_W-1:0]  ret_ctl;
    logic [3:0]        ret_lat;

    always_comb begin
        in_lat   = lat_tab[in_ctl];
        in_legal = (in_lat != 4'd0);
        in_slot  = SLOT_W'(in_lat);

        // A new op lands in slot L of the next scoreboard state. The op
        // that would occupy that slot after the shift sits in slot L+1 now,
        // so a set bit there means both results would need the single
        // capture port on the same cycle.
        in_ready = !rst && !flush && !due_q[in_slot + SLOT_W'(1)];
        accept   = in_valid && in_ready;

`ifdef FPU_ISSUE_ILLEGAL_TRAP_EN
        // Illegal codes enter the scoreboard with latency 0 and retire as
        // an error two cycles after acceptance.
        enq      = accept;
`else
        // Illegal codes are consumed but never tracked.
        enq      = accept && in_legal;
`endif

        ret      = due_q[0];
        ret_ctl  = ctl_q[0];
        ret_lat  = lat_tab[ret_ctl];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Scoreboard shifts down one slot per cycle.
        due_d = {1'b0, due_q[NSLOT-1:1]};
        for (int i = 0; i < NSLOT - 1; i++) begin
            tag_d[i] = tag_q[i+1];
            ctl_d[i] = ctl_q[i+1];
        end
        tag_d[NSLOT-1] = '0;
        ctl_d[NSLOT-1] = '0;

        if (enq) begin
            due_d[in_slot] = 1'b1;
            tag_d[in_slot] = in_tag;
            ctl_d[in_slot] = in_ctl;
        end

        // Start pulse only for codes that map to a real unit.
        go_d = (accept && in_legal) ? ({{(NOP-1){1'b0}}, 1'b1} << in_ctl) : '0;

        // Result capture from slot 0.
        ov_d   = ret;
        otag_d = tag_q[0];
        if (ret_lat == 4'd0) begin
            oy_d = '0;
        end else if ((ret_ctl == CTL_FEQ) || (ret_ctl == CTL_FLE)) begin
            oy_d = WIDTH'(y_tab[ret_ctl][0]);
        end else begin
            oy_d = y_tab[ret_ctl];
        end

`ifdef FPU_ISSUE_ILLEGAL_TRAP_EN
        oerr_d = (ret_lat == 4'd0);
`else
        oerr_d = 1'b0;
`endif

        inf_d = inf_q + INF_W'(enq) - INF_W'(ret);

        // Flush drops everything, including a capture due on this edge.
        if (flush) begin
            due_d = '0;
            for (int i = 0; i < NSLOT; i++) begin
                tag_d[i] = '0;
                ctl_d[i] = '0;
            end
            ov_d  = 1'b0;
            inf_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            due_q <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                tag_q[i] <= '0;
                ctl_q[i] <= '0;
            end
            go_q   <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            ov_q   <= 1'b0;
            otag_q <= '0;
            oy_q   <= '0;
            oerr_q <= 1'b0;
            inf_q  <= '0;
        end else begin
            due_q <= due_d;
            for (int i = 0; i < NSLOT; i++) begin
                tag_q[i] <= tag_d[i];
                ctl_q[i] <= ctl_d[i];
            end
            go_q <= go_d;
            if (accept) begin
                x1_q <= in_x1;
                x2_q <= in_x2;
            end
            ov_q <= ov_d;
            // Result fields hold their last values between strobes.
            if (ov_d) begin
                otag_q <= otag_d;
                oy_q   <= oy_d;
                oerr_q <= oerr_d;
            end
            inf_q <= inf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign unit_go   = go_q;
    assign unit_x1   = x1_q;
    assign unit_x2   = x2_q;
    assign out_valid = ov_q;
    assign out_tag   = otag_q;
    assign out_y     = oy_q;
    assign out_err   = oerr_q;
    assign inflight  = inf_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_seq.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_issue_seq
//  Description : Directed self-checking bench for fpu_issue_seq. A small
//                pipelined unit model answers every unit_go after the table
//                latency and drives a marker value on all other cycles, so a
//                capture on the wrong cycle shows up as a wrong out_y.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_fpu_issue_seq;

    localparam int WIDTH   = 32;
    localparam int CTL_W   = 4;
    localparam int TAG_W   = 4;
    localparam int MAX_LAT = 15;
    localparam int NOP     = 16;
    localparam logic [63:0] LAT = 64'h0111_1000_1943_2200;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTL_W-1:0]  in_ctl;
    logic [TAG_W-1:0]  in_tag;
    logic [WIDTH-1:0]  in_x1;
    logic [WIDTH-1:0]  in_x2;
    logic              flush;
    logic [NOP-1:0]    unit_go;
    logic [WIDTH-1:0]  unit_x1;
    logic [WIDTH-1:0]  unit_x2;
    logic [NOP*WIDTH-1:0] unit_y = '0;
    logic              out_valid;
    logic [TAG_W-1:0]  out_tag;
    logic [WIDTH-1:0]  out_y;
    logic              out_err;
    logic [4:0]        inflight;

    int total = 0;
    int bad   = 0;
    int cy    = 0;

    always #5 clk = ~clk;

    fpu_issue_seq #(
        .WIDTH     (WIDTH),
        .CTL_W     (CTL_W),
        .TAG_W     (TAG_W),
        .MAX_LAT   (MAX_LAT),
        .LAT_TABLE (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctl    (in_ctl),
        .in_tag    (in_tag),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .flush     (flush),
        .unit_go   (unit_go),
        .unit_x1   (unit_x1),
        .unit_x2   (unit_x2),
        .unit_y    (unit_y),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .out_y     (out_y),
        .out_err   (out_err),
        .inflight  (inflight)
    );

    // Unit result function: the fadd test vector returns its real sum,
    // everything else gets an arbitrary but operand-dependent value.
    function automatic logic [31:0] unit_fn(input int k, input logic [31:0] a, input logic [31:0] b);
        if (k == 2 && a == 32'h3F80_0000 && b == 32'h4000_0000)
            return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'(k);
    endfunction

    // ------------------------------------------------------------------
    // Pipelined unit model: go in cycle g -> result on slice k in g+L only
    // ------------------------------------------------------------------
    bit          sch_v [NOP][32];
    logic [31:0] sch_d [NOP][32];
    int          mcyc = 0;

    always @(posedge clk) begin
        int l;
        int s;
        #1;
        mcyc++;
        for (int k = 0; k < NOP; k++) begin
            if (sch_v[k][mcyc % 32]) begin
                unit_y[k*32 +: 32] = sch_d[k][mcyc % 32];
                sch_v[k][mcyc % 32] = 1'b0;
            end else begin
                unit_y[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
            end
        end
        for (int k = 0; k < NOP; k++) begin
            if (unit_go[k]) begin
                l = int'(LAT[k*4 +: 4]);
                s = (mcyc + l) % 32;
                sch_v[k][s] = 1'b1;
                sch_d[k][s] = unit_fn(k, unit_x1, unit_x2);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        cy++;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_ctl   = '0;
        in_tag   = '0;
        in_x1    = '0;
        in_x2    = '0;
    endtask

    task automatic offer(input int ctl, input int tag, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_ctl   = CTL_W'(ctl);
        in_tag   = TAG_W'(tag);
        in_x1    = a;
        in_x2    = b;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        idle();
        tick();
        tick();
        total++;
        if ({in_ready, unit_go, unit_x1, unit_x2, out_valid, out_tag, out_y, out_err, inflight} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b go=%h x1=%h x2=%h ov=%b tag=%h y=%h err=%b inf=%0d want all 0",
                     in_ready, unit_go, unit_x1, unit_x2, out_valid, out_tag, out_y, out_err, inflight);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_fadd();
        int a;
        offer(2, 3, 32'h3F80_0000, 32'h4000_0000);
        a = cy;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL fadd_ready: got %b want 1", in_ready); end
        tick();
        idle();
        total++;
        if (unit_go !== 16'h0004) begin bad++; $display("FAIL fadd_go: got %h want 0004", unit_go); end
        total++;
        if ({unit_x1, unit_x2} !== {32'h3F80_0000, 32'h4000_0000}) begin
            bad++; $display("FAIL fadd_operands: got %h %h want 3f800000 40000000", unit_x1, unit_x2);
        end
        total++;
        if (inflight !== 5'd1) begin bad++; $display("FAIL fadd_inflight1: got %0d want 1", inflight); end
        while (cy < a + 6) begin
            tick();
            total++;
            if (unit_go !== 16'h0000) begin bad++; $display("FAIL fadd_go_once: cycle a+%0d got %h want 0", cy - a, unit_go); end
            total++;
            if (out_valid !== (cy == a + 4)) begin
                bad++; $display("FAIL fadd_out_valid: cycle a+%0d got %b want %b", cy - a, out_valid, (cy == a + 4));
            end
            if (cy == a + 4 || cy == a + 5) begin
                // a+5 also checks that the result fields hold after the strobe.
                total++;
                if ({out_tag, out_y} !== {4'd3, 32'h4040_0000}) begin
                    bad++; $display("FAIL fadd_result: cycle a+%0d got tag=%h y=%h want tag=3 y=40400000", cy - a, out_tag, out_y);
                end
                total++;
                if (inflight !== 5'd0) begin bad++; $display("FAIL fadd_inflight0: got %0d want 0", inflight); end
            end
        end
    endtask

    task automatic test_overlap();
        int a;
        int peak;
        logic [31:0] y_div;
        logic [31:0] y_add;
        y_div = unit_fn(6, 32'h1234_5678, 32'h0F0F_0F0F);
        y_add = unit_fn(2, 32'h1111_1111, 32'h2222_2222);
        offer(6, 1, 32'h1234_5678, 32'h0F0F_0F0F);
        a = cy;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ovl_div_ready: got %b want 1", in_ready); end
        tick();
        offer(2, 2, 32'h1111_1111, 32'h2222_2222);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ovl_add_ready: got %b want 1", in_ready); end
        tick();
        idle();
        peak = 0;
        while (cy <= a + 13) begin
            if (int'(inflight) > peak) peak = int'(inflight);
            total++;
            if (out_valid !== (cy == a + 5 || cy == a + 11)) begin
                bad++; $display("FAIL ovl_out_valid: cycle a+%0d got %b", cy - a, out_valid);
            end
            if (cy == a + 5) begin
                total++;
                if ({out_tag, out_y} !== {4'd2, y_add}) begin
                    bad++; $display("FAIL ovl_add_result: got tag=%h y=%h want tag=2 y=%h", out_tag, out_y, y_add);
                end
            end
            if (cy == a + 11) begin
                total++;
                if ({out_tag, out_y} !== {4'd1, y_div}) begin
                    bad++; $display("FAIL ovl_div_result: got tag=%h y=%h want tag=1 y=%h", out_tag, out_y, y_div);
                end
            end
            tick();
        end
        total++;
        if (peak !== 2) begin bad++; $display("FAIL ovl_peak_inflight: got %0d want 2", peak); end
    endtask

    task automatic test_collision();
        int a;
        logic [31:0] y_div;
        logic [31:0] y_add;
        y_div = unit_fn(6, 32'hCAFE_0001, 32'h0000_1234);
        y_add = unit_fn(2, 32'h0BAD_F00D, 32'h7777_0000);
        offer(6, 4, 32'hCAFE_0001, 32'h0000_1234);
        a = cy;
        tick();
        idle();
        while (cy < a + 7) tick();
        offer(2, 5, 32'h0BAD_F00D, 32'h7777_0000);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL coll_block: got in_ready=%b want 0", in_ready); end
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL coll_release: got in_ready=%b want 1", in_ready); end
        total++;
        if (unit_go !== 16'h0000) begin bad++; $display("FAIL coll_no_accept: got go=%h want 0", unit_go); end
        tick();
        idle();
        total++;
        if (unit_go !== 16'h0004) begin bad++; $display("FAIL coll_go: got go=%h want 0004", unit_go); end
        while (cy <= a + 13) begin
            total++;
            if (out_valid !== (cy == a + 11 || cy == a + 12)) begin
                bad++; $display("FAIL coll_out_valid: cycle a+%0d got %b", cy - a, out_valid);
            end
            if (cy == a + 11) begin
                total++;
                if ({out_tag, out_y} !== {4'd4, y_div}) begin
                    bad++; $display("FAIL coll_div_result: got tag=%h y=%h want tag=4 y=%h", out_tag, out_y, y_div);
                end
            end
            if (cy == a + 12) begin
                total++;
                if ({out_tag, out_y} !== {4'd5, y_add}) begin
                    bad++; $display("FAIL coll_add_result: got tag=%h y=%h want tag=5 y=%h", out_tag, out_y, y_add);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa;
        logic [31:0] xb;
        logic [31:0] ye;
        for (int c = 0; c <= 16; c++) begin
            if (c < 10) begin
                xa = 32'(c) * 32'h0101_0101;
                xb = 32'h8000_0000 >> c;
                offer(4, c, xa, xb);
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: op %0d got %b want 1", c, in_ready); end
            end else begin
                idle();
            end
            total++;
            if (out_valid !== (c >= 5 && c < 15)) begin
                bad++; $display("FAIL b2b_out_valid: cycle a+%0d got %b", c, out_valid);
            end
            if (c >= 5 && c < 15) begin
                xa = 32'(c - 5) * 32'h0101_0101;
                xb = 32'h8000_0000 >> (c - 5);
                ye = unit_fn(4, xa, xb);
                total++;
                if ({out_tag, out_y} !== {TAG_W'(c - 5), ye}) begin
                    bad++; $display("FAIL b2b_result: cycle a+%0d got tag=%h y=%h want tag=%h y=%h", c, out_tag, out_y, TAG_W'(c - 5), ye);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        int a;
        logic [31:0] y_add;
        y_add = unit_fn(2, 32'h0000_00AA, 32'h0000_5500);
        offer(6, 6, 32'h1357_9BDF, 32'h2468_ACE0);
        a = cy;
        tick();
        idle();
        while (cy < a + 4) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_pre_valid: cycle a+%0d got %b want 0", cy - a, out_valid); end
            tick();
        end
        flush  = 1'b1;
        in_ctl = 4'd2;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        total++;
        if (inflight !== 5'd0) begin bad++; $display("FAIL flush_inflight: got %0d want 0", inflight); end
        offer(2, 8, 32'h0000_00AA, 32'h0000_5500);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_new_ready: got %b want 1", in_ready); end
        tick();
        idle();
        while (cy <= a + 13) begin
            total++;
            if (out_valid !== (cy == a + 9)) begin
                bad++; $display("FAIL flush_out_valid: cycle a+%0d got %b", cy - a, out_valid);
            end
            if (cy == a + 9) begin
                total++;
                if ({out_tag, out_y} !== {4'd8, y_add}) begin
                    bad++; $display("FAIL flush_new_result: got tag=%h y=%h want tag=8 y=%h", out_tag, out_y, y_add);
                end
            end
            tick();
        end
    endtask

    task automatic test_feq();
        int a;
        offer(11, 10, 32'hFFFF_FFF0, 32'h0000_0000);
        a = cy;
        tick();
        idle();
        while (cy <= a + 5) begin
            total++;
            if (out_valid !== (cy == a + 3)) begin
                bad++; $display("FAIL feq_out_valid: cycle a+%0d got %b", cy - a, out_valid);
            end
            if (cy == a + 3) begin
                // Unit slice is FFFFFFFB; only bit 0 comes back.
                total++;
                if ({out_tag, out_y} !== {4'd10, 32'h0000_0001}) begin
                    bad++; $display("FAIL feq_result: got tag=%h y=%h want tag=a y=00000001", out_tag, out_y);
                end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        int a;
        offer(15, 7, 32'h5555_5555, 32'hAAAA_AAAA);
        a = cy;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready: got %b want 1", in_ready); end
        tick();
        idle();
        total++;
        if (unit_go !== 16'h0000) begin bad++; $display("FAIL ill_no_go: got %h want 0", unit_go); end
`ifdef FPU_ISSUE_ILLEGAL_TRAP_EN
        total++;
        if (inflight !== 5'd1) begin bad++; $display("FAIL ill_inflight: got %0d want 1", inflight); end
        while (cy <= a + 5) begin
            tick();
            total++;
            if (out_valid !== (cy == a + 2)) begin
                bad++; $display("FAIL ill_out_valid: cycle a+%0d got %b", cy - a, out_valid);
            end
            if (cy == a + 2) begin
                total++;
                if ({out_err, out_tag, out_y} !== {1'b1, 4'd7, 32'h0}) begin
                    bad++; $display("FAIL ill_result: got err=%b tag=%h y=%h want err=1 tag=7 y=0", out_err, out_tag, out_y);
                end
            end
        end
`else
        total++;
        if (inflight !== 5'd0) begin bad++; $display("FAIL ill_inflight: got %0d want 0", inflight); end
        while (cy <= a + 5) begin
            tick();
            total++;
            if ({out_valid, out_err, inflight} !== 7'd0) begin
                bad++; $display("FAIL ill_dropped: cycle a+%0d got ov=%b err=%b inf=%0d want 0", cy - a, out_valid, out_err, inflight);
            end
        end
`endif
    endtask

    task automatic test_rst_mid();
        int a;
        offer(6, 9, 32'hFEED_BEEF, 32'h0101_0101);
        a = cy;
        tick();
        idle();
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({in_ready, unit_go, unit_x1, unit_x2, out_valid, out_tag, out_y, out_err, inflight} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: got ready=%b go=%h x1=%h x2=%h ov=%b tag=%h y=%h err=%b inf=%0d want all 0",
                     in_ready, unit_go, unit_x1, unit_x2, out_valid, out_tag, out_y, out_err, inflight);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        while (cy <= a + 14) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid: cycle a+%0d got %b want 0", cy - a, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_overlap();
        test_collision();
        test_back_to_back();
        test_flush();
        test_feq();
        test_illegal();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
